load_div_stall_ctrl: RTL and testbench
======================================

# load_div_stall_ctrl

Pipeline stall controller for the five-stage CPU. It detects load-use hazards that the ID-stage forwarding paths (EX/MEM/WB to register-file read ports) cannot resolve, and sequences the multi-cycle divider occupying EX. It drives the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sits beside ID/EX and contains the only stall FSM in the core.

## Interface
Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles after the start cycle (legal range 2..64)
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal range 1..3)

Ports:
- clk  in  1  core clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- id_re1  in  1  ID read port 1 in use
- id_raddr1  in  5  ID read address 1
- id_re2  in  1  ID read port 2 in use
- id_raddr2  in  5  ID read address 2
- ex_is_load  in  1  instruction in EX is a load (lw/lb/lbu/lh/lhu)
- ex_wreg  in  1  instruction in EX writes the register file
- ex_waddr  in  5  destination register of the instruction in EX
- ex_div_start  in  1  instruction in EX is div/divu
- stall  out  6  bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. stall[i]=1 holds stage i. stall[i]=1 with stall[i+1]=0 inserts a bubble into stage i+1.
- div_busy  out  1  registered; divider iterating
- div_done  out  1  registered; one-cycle pulse, quotient/remainder valid

## Operation
- States: IDLE, LOAD_WAIT, DIV_RUN, DIV_DONE. A registered counter cnt (7 bits) is shared by LOAD_WAIT and DIV_RUN.
- Hazard term: haz = ex_is_load & ex_wreg & (ex_waddr != 0) & ((id_re1 & id_raddr1 == ex_waddr) | (id_re2 & id_raddr2 == ex_waddr)).
- IDLE:
  - If ex_div_start=1: stall = 6'b001111. Next state is DIV_RUN with cnt = DIV_CYCLES-1.
  - Else if haz=1: stall = 6'b000111. If LOAD_BUBBLES > 1, next state is LOAD_WAIT with cnt = LOAD_BUBBLES-2. Otherwise stay in IDLE.
  - Else: stall = 0.
  - ex_div_start takes priority when asserted together with ex_is_load. That combination is illegal but has defined behaviour.
- LOAD_WAIT:
  - stall = 6'b000111. All inputs are ignored.
  - cnt decrements each cycle. When cnt == 0, next state is IDLE.
- DIV_RUN:
  - stall = 6'b001111. div_busy = 1. Inputs are ignored.
  - cnt decrements each cycle. When cnt == 0, next state is DIV_DONE.
- DIV_DONE:
  - stall = 0. div_done = 1. ex_div_start is ignored; the same div is still in EX.
  - Next state is IDLE unconditionally.
- stall is a Mealy output (combinational from state and inputs). div_busy and div_done are decoded from registered state only.
- Reset, including mid-operation: state goes to IDLE and cnt to 0 immediately. stall, div_busy and div_done are all 0 while rst=1 and in the first cycle after release, unless that cycle's inputs request a stall.

## Timing
- Load-use: the stall appears in the same cycle as haz. With the default LOAD_BUBBLES=1, ID is held exactly 1 cycle. In general ID is held LOAD_BUBBLES cycles and one bubble per cycle enters EX.
- Divider:
  - Start cycle T0 plus DIV_CYCLES cycles in DIV_RUN, so PC/IF/ID/EX are held DIV_CYCLES+1 cycles.
  - div_busy is high from T1 through T0+DIV_CYCLES.
  - div_done is high at T0+DIV_CYCLES+1 with stall = 0, so the div leaves EX at the end of that cycle.
- Back-to-back divs: the second div reaches EX at T0+DIV_CYCLES+2 and starts a fresh sequence in IDLE.
- A load-use hazard on the instruction following a div is evaluated only once the FSM has returned to IDLE.
- MEM and WB are never stalled by this block (stall[5:4] = 0 always).

## Test plan
- Load-use, default parameters: ex_is_load=1, ex_wreg=1, ex_waddr=5, id_re1=1, id_raddr1=5 -> stall=6'b000111 for 1 cycle; next cycle, with EX holding a bubble (ex_is_load=0), stall=0.
- Non-hazards:
  - ex_waddr=0 with id_raddr1=0 -> stall=0.
  - id_re2=0 with id_raddr2=ex_waddr -> stall=0.
  - ex_wreg=0 -> stall=0.
- LOAD_BUBBLES=2: same stimulus held for 2 cycles -> stall=6'b000111 for exactly 2 cycles, and the FSM visits LOAD_WAIT once.
- Divide, DIV_CYCLES=32: ex_div_start=1 held -> stall=6'b001111 for 33 cycles, div_busy high for cycles 1..32, div_done pulse at cycle 33 with stall=0, then IDLE.
- Back-to-back div then dependent load: the second div restarts the 33-cycle sequence one cycle after the first div_done. A following load-use pair then stalls exactly 1 cycle.
- Reset mid-divide: assert rst at DIV_RUN cycle 10 -> stall, div_busy and div_done go to 0 immediately without a clock edge. After release with ex_div_start=0, state is IDLE and stall=0.

Source files
------------

// File: rtl/load_div_stall_ctrl_if.sv
// load_div_stall_ctrl_if: ID/EX hazard inputs and stall/divider status outputs of the stall controller.
interface load_div_stall_ctrl_if;
    logic       id_re1;
    logic [4:0] id_raddr1;
    logic       id_re2;
    logic [4:0] id_raddr2;
    logic       ex_is_load;
    logic       ex_wreg;
    logic [4:0] ex_waddr;
    logic       ex_div_start;
    logic [5:0] stall;
    logic       div_busy;
    logic       div_done;
    modport master (
        output id_re1, id_raddr1, id_re2, id_raddr2, ex_is_load, ex_wreg, ex_waddr, ex_div_start,
        input  stall, div_busy, div_done
    );
    modport slave (
        input  id_re1, id_raddr1, id_re2, id_raddr2, ex_is_load, ex_wreg, ex_waddr, ex_div_start,
        output stall, div_busy, div_done
    );
endinterface

// File: rtl/load_div_stall_ctrl.sv
// load_div_stall_ctrl: load-use hazard detection and multi-cycle divider sequencing,
// producing the pipeline stall vector (PC, IF, ID, EX, MEM, WB).
module load_div_stall_ctrl #(
    parameter int DIV_CYCLES   = 32,
    parameter int LOAD_BUBBLES = 1
) (
    input logic                    clk,
    input logic                    rst,
    load_div_stall_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, DIV_RUN, DIV_DONE} state_e;
    localparam logic [5:0] STALL_LOAD = 6'b000111;
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] stall_d;
    logic       haz;
    assign haz = bus.ex_is_load & bus.ex_wreg & (bus.ex_waddr != 5'd0) &
                 ((bus.id_re1 & (bus.id_raddr1 == bus.ex_waddr)) |
                  (bus.id_re2 & (bus.id_raddr2 == bus.ex_waddr)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = '0;
        case (state_q)
            IDLE: begin
                // div wins over a simultaneous load: the combination is illegal but must stay defined
                if (bus.ex_div_start) begin
                    stall_d = STALL_DIV;
                    state_d = DIV_RUN;
                    cnt_d   = 7'(DIV_CYCLES - 1);
                end else if (haz) begin
                    stall_d = STALL_LOAD;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = LOAD_WAIT;
                        cnt_d   = 7'(LOAD_BUBBLES - 2);
                    end
                end
            end
            LOAD_WAIT: begin
                stall_d = STALL_LOAD;
                cnt_d   = (cnt_q == 7'd0) ? 7'd0 : cnt_q - 7'd1;
                state_d = (cnt_q == 7'd0) ? IDLE : LOAD_WAIT;
            end
            DIV_RUN: begin
                stall_d = STALL_DIV;
                cnt_d   = (cnt_q == 7'd0) ? 7'd0 : cnt_q - 7'd1;
                state_d = (cnt_q == 7'd0) ? DIV_DONE : DIV_RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.stall    = rst ? 6'd0 : stall_d;
    assign bus.div_busy = (state_q == DIV_RUN);
    assign bus.div_done = (state_q == DIV_DONE);
endmodule

// File: tb/tb_load_div_stall_ctrl.sv
// tb_load_div_stall_ctrl: two controllers (default and LOAD_BUBBLES=2/DIV_CYCLES=3) driven
// with the same directed vectors, checked every cycle against a remaining-cycles model.
module tb_load_div_stall_ctrl;
    localparam int DC0 = 32, LB0 = 1, DC1 = 3, LB1 = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    load_div_stall_ctrl_if if0 ();
    load_div_stall_ctrl_if if1 ();
    load_div_stall_ctrl #(.DIV_CYCLES(DC0), .LOAD_BUBBLES(LB0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    load_div_stall_ctrl #(.DIV_CYCLES(DC1), .LOAD_BUBBLES(LB1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    always #5 clk = ~clk;

    int busy_left [2];
    int load_left [2];
    bit in_done   [2];

    task automatic chk(input string n, input logic [5:0] a, input logic [5:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", n, a, e, $time);
        end
    endtask

    function automatic bit haz();
        return if0.ex_is_load && if0.ex_wreg && if0.ex_waddr != 0 &&
               ((if0.id_re1 && if0.id_raddr1 == if0.ex_waddr) || (if0.id_re2 && if0.id_raddr2 == if0.ex_waddr));
    endfunction

    function automatic logic [5:0] exp_stall(int i);
        if (rst) return 6'd0;
        if (busy_left[i] > 0) return 6'b001111;
        if (in_done[i]) return 6'd0;
        if (load_left[i] > 0) return 6'b000111;
        if (if0.ex_div_start) return 6'b001111;
        return haz() ? 6'b000111 : 6'd0;
    endfunction

    // model: cycles of divide / extra load bubbles still owed, plus a pending done cycle
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy_left[i] = 0; load_left[i] = 0; in_done[i] = 0;
            end else if (busy_left[i] > 0) begin
                busy_left[i]--;
                if (busy_left[i] == 0) in_done[i] = 1;
            end else if (in_done[i]) begin
                in_done[i] = 0;
            end else if (load_left[i] > 0) begin
                load_left[i]--;
            end else if (if0.ex_div_start) begin
                busy_left[i] = (i == 0) ? DC0 : DC1;
            end else if (haz()) begin
                load_left[i] = ((i == 0) ? LB0 : LB1) - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall0", if0.stall, exp_stall(0));
        chk("busy0", 6'(if0.div_busy), 6'(!rst && busy_left[0] > 0));
        chk("done0", 6'(if0.div_done), 6'(!rst && in_done[0]));
        chk("stall1", if1.stall, exp_stall(1));
        chk("busy1", 6'(if1.div_busy), 6'(!rst && busy_left[1] > 0));
        chk("done1", 6'(if1.div_done), 6'(!rst && in_done[1]));
    end

    task automatic drive(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2,
                         input logic ld, input logic wr, input logic [4:0] wa, input logic ds);
        if0.id_re1 = re1; if0.id_raddr1 = a1; if0.id_re2 = re2; if0.id_raddr2 = a2;
        if0.ex_is_load = ld; if0.ex_wreg = wr; if0.ex_waddr = wa; if0.ex_div_start = ds;
        if1.id_re1 = re1; if1.id_raddr1 = a1; if1.id_re2 = re2; if1.id_raddr2 = a2;
        if1.ex_is_load = ld; if1.ex_wreg = wr; if1.ex_waddr = wa; if1.ex_div_start = ds;
    endtask

    // inputs are applied 2 time units after a rising edge; outputs sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    int n_stall, n_busy, n_done, n_ld1;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", if0.stall, 6'd0);
        chk("rst_busy", 6'(if0.div_busy), 6'd0);
        rst = 1'b0;
        // load-use on port 1
        drive(1, 5, 0, 0, 1, 1, 5, 0);
        @(negedge clk);
        chk("lu_stall0", if0.stall, 6'b000111);
        chk("lu_stall1", if1.stall, 6'b000111);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_bubble0", if0.stall, 6'd0);
        chk("lu_wait1", if1.stall, 6'b000111);
        next_cycle();
        @(negedge clk);
        chk("lu_idle1", if1.stall, 6'd0);
        next_cycle();
        // non-hazards
        drive(1, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("nh_r0", if0.stall, 6'd0);
        next_cycle();
        drive(0, 0, 0, 7, 1, 1, 7, 0);
        @(negedge clk);
        chk("nh_re2off", if0.stall, 6'd0);
        next_cycle();
        drive(1, 9, 0, 0, 1, 0, 9, 0);
        @(negedge clk);
        chk("nh_nowreg", if0.stall, 6'd0);
        next_cycle();
        // hazard through port 2, LOAD_BUBBLES=2 instance counted over the stalled window
        n_ld1 = 0;
        drive(0, 0, 1, 12, 1, 1, 12, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("lu2_stall0", if0.stall, 6'b000111);
            if (if1.stall == 6'b000111) n_ld1++;
            next_cycle();
            if (k == 1) drive(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("lb2_count", 6'(n_ld1), 6'd2);
        // divide held high: first sequence then back-to-back second one
        n_stall = 0; n_busy = 0; n_done = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 68; k++) begin
            @(negedge clk);
            if (k < 34) begin
                if (if0.stall == 6'b001111) n_stall++;
                if (if0.div_busy) n_busy++;
                if (if0.div_done) n_done++;
            end
            if (k == 1) chk("div_busy_t1", 6'(if0.div_busy), 6'd1);
            if (k == 33) chk("div_done_t33", {if0.stall[4:0], if0.div_done}, 6'b000001);
            if (k == 34) chk("div2_start", {if0.stall[4:0], if0.div_busy}, 6'b011110);
            if (k == 67) chk("div2_done", 6'(if0.div_done), 6'd1);
            next_cycle();
        end
        chk("div_stall_cnt", 6'(n_stall), 6'd33);
        chk("div_busy_cnt", 6'(n_busy), 6'd32);
        chk("div_done_cnt", 6'(n_done), 6'd1);
        // dependent load after the second div
        drive(1, 3, 0, 0, 1, 1, 3, 0);
        @(negedge clk);
        chk("post_div_lu", if0.stall, 6'b000111);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_div_bub", if0.stall, 6'd0);
        next_cycle();
        repeat (4) next_cycle();
        // reset in the middle of a divide
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) next_cycle();
        chk("pre_rst_busy", {if0.stall[4:0], if0.div_busy}, 6'b011111);
        #1 rst = 1'b1;
        #1;
        chk("arst_stall", if0.stall, 6'd0);
        chk("arst_busy", 6'(if0.div_busy), 6'd0);
        chk("arst_done", 6'(if0.div_done), 6'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", if0.stall, 6'd0);
        chk("post_rst_busy", 6'(if0.div_busy), 6'd0);
        next_cycle();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
